// File: rtl/dram_cmd_seq.sv
// dram_cmd_seq: per-request DRAM command sequencer placed after the open-row
// policy block. It looks each request up in the policy table, issues
// PRE/ACT/RD/WR with tRP/tRCD/burst spacing, and serialises refresh as
// PREA -> REF while clearing the policy table.
//
// Optional build macro: DRAM_CMD_SEQ_STATS_EN adds saturating 16-bit
// hit/miss/conflict counters (stat_hit_o, stat_miss_o, stat_conflict_o).
//
// state      | meaning
// -----------+------------------------------------------------------------
// IDLE       | ready for a request; refresh request takes priority
// LOOKUP     | strobe policy lookup for the latched bank/row
// WAIT_STAT  | decode registered policy status (HIT/MISS/CONFLICT/retry)
// ACT        | issue ACT with the latched row
// WAIT_RCD   | ACT -> column command spacing
// COL        | issue RD or WR with the latched column
// WAIT_BURST | burst spacing before accepting the next request
// PRE        | issue PRE and invalidate the bank's open row in the policy
// WAIT_RP    | precharge spacing, then LOOKUP (after PRE) or REF (after PREA)
// PREA       | precharge all banks and clear the policy table
// REF        | issue REF, pulse ref_ack
// WAIT_RFC   | refresh recovery before returning to IDLE
module dram_cmd_seq #(
  parameter int T_RCD   = 4,
  parameter int T_RP    = 4,
  parameter int T_BURST = 4,
  parameter int T_RFC   = 8,
  parameter int CNT_W   = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [1:0]  req_bg_i,
  input  logic [1:0]  req_bank_i,
  input  logic [15:0] req_row_i,
  input  logic [9:0]  req_col_i,
  input  logic        ref_req_i,
  output logic        ref_ack_o,
  output logic        pol_req_en_o,
  output logic        pol_row_resolve_o,
  output logic        pol_refresh_o,
  output logic [1:0]  pol_bank_group_o,
  output logic [1:0]  pol_bank_o,
  output logic [15:0] pol_row_o,
  input  logic [1:0]  pol_row_stat_i,
  output logic        cmd_valid_o,
  output logic [2:0]  cmd_o,
  output logic [1:0]  cmd_bg_o,
  output logic [1:0]  cmd_bank_o,
  output logic [15:0] cmd_row_o,
  output logic [9:0]  cmd_col_o
`ifdef DRAM_CMD_SEQ_STATS_EN
  ,
  output logic [15:0] stat_hit_o,
  output logic [15:0] stat_miss_o,
  output logic [15:0] stat_conflict_o
`endif
);

  typedef enum logic [3:0] {
    S_IDLE, S_LOOKUP, S_WAIT_STAT, S_ACT, S_WAIT_RCD, S_COL,
    S_WAIT_BURST, S_PRE, S_WAIT_RP, S_PREA, S_REF, S_WAIT_RFC
  } state_t;

  localparam logic [2:0] CMD_NOP  = 3'd0;
  localparam logic [2:0] CMD_ACT  = 3'd1;
  localparam logic [2:0] CMD_RD   = 3'd2;
  localparam logic [2:0] CMD_WR   = 3'd3;
  localparam logic [2:0] CMD_PRE  = 3'd4;
  localparam logic [2:0] CMD_PREA = 3'd5;
  localparam logic [2:0] CMD_REF  = 3'd6;

  localparam logic [1:0] ST_HIT      = 2'b01;
  localparam logic [1:0] ST_MISS     = 2'b10;
  localparam logic [1:0] ST_CONFLICT = 2'b11;

  // Wait states last T_x-1 cycles: load T_x-2 on entry, leave at zero.
  localparam logic [CNT_W-1:0] RCD_LD   = CNT_W'(T_RCD - 2);
  localparam logic [CNT_W-1:0] RP_LD    = CNT_W'(T_RP - 2);
  localparam logic [CNT_W-1:0] BURST_LD = CNT_W'(T_BURST - 2);
  localparam logic [CNT_W-1:0] RFC_LD   = CNT_W'(T_RFC - 2);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ret_ref_q, ret_ref_d;   // WAIT_RP exit: 1 -> REF, 0 -> LOOKUP
  logic              write_q, write_d;
  logic [1:0]        bg_q, bg_d;
  logic [1:0]        bank_q, bank_d;
  logic [15:0]       row_q, row_d;
  logic [9:0]        col_q, col_d;

  // State, wait counter and latched request registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      ret_ref_q <= 1'b0;
      write_q   <= 1'b0;
      bg_q      <= '0;
      bank_q    <= '0;
      row_q     <= '0;
      col_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ret_ref_q <= ret_ref_d;
      write_q   <= write_d;
      bg_q      <= bg_d;
      bank_q    <= bank_d;
      row_q     <= row_d;
      col_q     <= col_d;
    end
  end

  // Next-state, counter load/decrement and command/policy output decode.
  always_comb begin
    state_d           = state_q;
    cnt_d             = cnt_q;
    ret_ref_d         = ret_ref_q;
    write_d           = write_q;
    bg_d              = bg_q;
    bank_d            = bank_q;
    row_d             = row_q;
    col_d             = col_q;
    req_ready_o       = 1'b0;
    ref_ack_o         = 1'b0;
    pol_req_en_o      = 1'b0;
    pol_row_resolve_o = 1'b0;
    pol_refresh_o     = 1'b0;
    cmd_valid_o       = 1'b0;
    cmd_o             = CMD_NOP;
    cmd_bg_o          = '0;
    cmd_bank_o        = '0;
    cmd_row_o         = '0;
    cmd_col_o         = '0;

    case (state_q)
      S_IDLE: begin
        req_ready_o = !ref_req_i;
        if (ref_req_i) begin
          state_d = S_PREA;
        end else if (req_valid_i) begin
          write_d = req_write_i;
          bg_d    = req_bg_i;
          bank_d  = req_bank_i;
          row_d   = req_row_i;
          col_d   = req_col_i;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        pol_req_en_o = 1'b1;
        state_d      = S_WAIT_STAT;
      end
      S_WAIT_STAT: begin
        case (pol_row_stat_i)
          ST_HIT:      state_d = S_COL;
          ST_MISS:     state_d = S_ACT;
          ST_CONFLICT: state_d = S_PRE;
          default:     state_d = S_LOOKUP;
        endcase
      end
      S_ACT: begin
        cmd_valid_o = 1'b1;
        cmd_o       = CMD_ACT;
        cmd_bg_o    = bg_q;
        cmd_bank_o  = bank_q;
        cmd_row_o   = row_q;
        cnt_d       = RCD_LD;
        state_d     = S_WAIT_RCD;
      end
      S_WAIT_RCD: begin
        if (cnt_q == '0) state_d = S_COL;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_COL: begin
        cmd_valid_o = 1'b1;
        cmd_o       = write_q ? CMD_WR : CMD_RD;
        cmd_bg_o    = bg_q;
        cmd_bank_o  = bank_q;
        cmd_col_o   = col_q;
        cnt_d       = BURST_LD;
        state_d     = S_WAIT_BURST;
      end
      S_WAIT_BURST: begin
        if (cnt_q == '0) state_d = S_IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_PRE: begin
        // The invalidate lookup returns status 00, which nobody consumes.
        cmd_valid_o       = 1'b1;
        cmd_o             = CMD_PRE;
        cmd_bg_o          = bg_q;
        cmd_bank_o        = bank_q;
        pol_req_en_o      = 1'b1;
        pol_row_resolve_o = 1'b1;
        cnt_d             = RP_LD;
        ret_ref_d         = 1'b0;
        state_d           = S_WAIT_RP;
      end
      S_WAIT_RP: begin
        if (cnt_q == '0) state_d = ret_ref_q ? S_REF : S_LOOKUP;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_PREA: begin
        cmd_valid_o   = 1'b1;
        cmd_o         = CMD_PREA;
        pol_refresh_o = 1'b1;
        cnt_d         = RP_LD;
        ret_ref_d     = 1'b1;
        state_d       = S_WAIT_RP;
      end
      S_REF: begin
        cmd_valid_o = 1'b1;
        cmd_o       = CMD_REF;
        ref_ack_o   = 1'b1;
        cnt_d       = RFC_LD;
        state_d     = S_WAIT_RFC;
      end
      S_WAIT_RFC: begin
        if (cnt_q == '0) state_d = S_IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign pol_bank_group_o = bg_q;
  assign pol_bank_o       = bank_q;
  assign pol_row_o        = row_q;

`ifdef DRAM_CMD_SEQ_STATS_EN
  logic [15:0] hit_q, miss_q, conflict_q;

  // Saturating lookup-outcome counters; the retry status counts nothing.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hit_q      <= '0;
      miss_q     <= '0;
      conflict_q <= '0;
    end else if (state_q == S_WAIT_STAT) begin
      if (pol_row_stat_i == ST_HIT && hit_q != 16'hFFFF)
        hit_q <= hit_q + 16'd1;
      if (pol_row_stat_i == ST_MISS && miss_q != 16'hFFFF)
        miss_q <= miss_q + 16'd1;
      if (pol_row_stat_i == ST_CONFLICT && conflict_q != 16'hFFFF)
        conflict_q <= conflict_q + 16'd1;
    end
  end

  assign stat_hit_o      = hit_q;
  assign stat_miss_o     = miss_q;
  assign stat_conflict_o = conflict_q;
`endif

endmodule

// File: tb/tb_dram_cmd_seq.sv
// Bench for dram_cmd_seq. The bench plays the open-row policy block itself
// (a per-bank open-row table with optional random "busy" retries) and
// predicts the command stream cycle by cycle from the sequencing rules.
module tb_dram_cmd_seq;

  localparam int T_RCD   = 4;
  localparam int T_RP    = 4;
  localparam int T_BURST = 4;
  localparam int T_RFC   = 8;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_write_i;
  logic [1:0]  req_bg_i;
  logic [1:0]  req_bank_i;
  logic [15:0] req_row_i;
  logic [9:0]  req_col_i;
  logic        ref_req_i;
  logic        ref_ack_o;
  logic        pol_req_en_o;
  logic        pol_row_resolve_o;
  logic        pol_refresh_o;
  logic [1:0]  pol_bank_group_o;
  logic [1:0]  pol_bank_o;
  logic [15:0] pol_row_o;
  logic [1:0]  pol_row_stat_i;
  logic        cmd_valid_o;
  logic [2:0]  cmd_o;
  logic [1:0]  cmd_bg_o;
  logic [1:0]  cmd_bank_o;
  logic [15:0] cmd_row_o;
  logic [9:0]  cmd_col_o;
`ifdef DRAM_CMD_SEQ_STATS_EN
  logic [15:0] stat_hit_o, stat_miss_o, stat_conflict_o;
`endif

  dram_cmd_seq #(.T_RCD(T_RCD), .T_RP(T_RP), .T_BURST(T_BURST), .T_RFC(T_RFC), .CNT_W(8)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_write_i(req_write_i),
    .req_bg_i(req_bg_i), .req_bank_i(req_bank_i), .req_row_i(req_row_i), .req_col_i(req_col_i),
    .ref_req_i(ref_req_i), .ref_ack_o(ref_ack_o),
    .pol_req_en_o(pol_req_en_o), .pol_row_resolve_o(pol_row_resolve_o), .pol_refresh_o(pol_refresh_o),
    .pol_bank_group_o(pol_bank_group_o), .pol_bank_o(pol_bank_o), .pol_row_o(pol_row_o),
    .pol_row_stat_i(pol_row_stat_i),
    .cmd_valid_o(cmd_valid_o), .cmd_o(cmd_o), .cmd_bg_o(cmd_bg_o), .cmd_bank_o(cmd_bank_o),
    .cmd_row_o(cmd_row_o), .cmd_col_o(cmd_col_o)
`ifdef DRAM_CMD_SEQ_STATS_EN
    , .stat_hit_o(stat_hit_o), .stat_miss_o(stat_miss_o), .stat_conflict_o(stat_conflict_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: latched request as seen on pol_*, policy table, stats.
  logic [1:0]  lat_bg, lat_bank;
  logic [15:0] lat_row;
  bit          tv[16];
  logic [15:0] tr[16];
  int          m_hit, m_miss, m_conf;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic compare_outputs(input string tag, input logic cv, input logic [2:0] c,
                                 input logic [1:0] cbg, input logic [1:0] cbk,
                                 input logic [15:0] crow, input logic [9:0] ccol,
                                 input logic pen, input logic res, input logic refr,
                                 input logic ack, input logic rdy);
    check({tag, "/cmd"}, {cmd_valid_o, cmd_o, cmd_bg_o, cmd_bank_o, cmd_row_o, cmd_col_o},
          {cv, c, cbg, cbk, crow, ccol});
    check({tag, "/pol"}, {pol_req_en_o, pol_row_resolve_o, pol_refresh_o, ref_ack_o, req_ready_o,
                          pol_bank_group_o, pol_bank_o, pol_row_o},
          {pen, res, refr, ack, rdy, lat_bg, lat_bank, lat_row});
  endtask

  task automatic expect_cyc(input string tag, input logic cv, input logic [2:0] c,
                            input logic [1:0] cbg, input logic [1:0] cbk,
                            input logic [15:0] crow, input logic [9:0] ccol,
                            input logic pen, input logic res, input logic refr,
                            input logic ack, input logic rdy);
    @(negedge clk_i);
    compare_outputs(tag, cv, c, cbg, cbk, crow, ccol, pen, res, refr, ack, rdy);
  endtask

  task automatic expect_nop(input string tag);
    expect_cyc(tag, 0, 3'd0, 2'd0, 2'd0, 16'd0, 10'd0, 0, 0, 0, 0, 0);
  endtask

  // Advance to just after the next rising edge and present the policy status.
  task automatic step(input logic [1:0] st);
    @(posedge clk_i);
    #1;
    pol_row_stat_i = st;
  endtask

  // Mid-sequence noise: must all be ignored outside IDLE.
  task automatic rand_inputs();
    req_valid_i = 1'($urandom);
    ref_req_i   = 1'($urandom);
    req_write_i = 1'($urandom);
    req_bg_i    = 2'($urandom);
    req_bank_i  = 2'($urandom);
    req_row_i   = 16'($urandom);
    req_col_i   = 10'($urandom);
  endtask

  task automatic clear_table();
    for (int i = 0; i < 16; i++) tv[i] = 1'b0;
  endtask

  task automatic policy(input logic [1:0] bg, input logic [1:0] bk, input logic [15:0] row,
                        input int retry_pct, output logic [1:0] st);
    int idx;
    idx = {bg, bk};
    if (int'($urandom_range(0, 99)) < retry_pct) begin
      st = 2'b00;
    end else if (!tv[idx]) begin
      tv[idx] = 1'b1;
      tr[idx] = row;
      m_miss++;
      st = 2'b10;
    end else if (tr[idx] == row) begin
      m_hit++;
      st = 2'b01;
    end else begin
      m_conf++;
      st = 2'b11;
    end
  endtask

  task automatic do_req(input logic w, input logic [1:0] bg, input logic [1:0] bk,
                        input logic [15:0] row, input logic [9:0] col,
                        input int retry_pct, input bit abort);
    logic [1:0] st;
    bit done;
    int guard;
    step(2'b00);
    req_valid_i = 1'b1; ref_req_i = 1'b0; req_write_i = w;
    req_bg_i = bg; req_bank_i = bk; req_row_i = row; req_col_i = col;
    expect_cyc("accept", 0, 3'd0, 2'd0, 2'd0, 16'd0, 10'd0, 0, 0, 0, 0, 1);
    lat_bg = bg; lat_bank = bk; lat_row = row;
    step(2'b00); rand_inputs();
    expect_cyc("lookup", 0, 3'd0, 2'd0, 2'd0, 16'd0, 10'd0, 1, 0, 0, 0, 0);
    done = 0;
    guard = 0;
    while (!done && guard < 32) begin
      guard++;
      policy(bg, bk, row, retry_pct, st);
      step(st); rand_inputs();
      expect_nop("wait_stat");
      case (st)
        2'b00: begin
          step(2'b00); rand_inputs();
          expect_cyc("relookup", 0, 3'd0, 2'd0, 2'd0, 16'd0, 10'd0, 1, 0, 0, 0, 0);
        end
        2'b01: begin
          step(2'b00); rand_inputs();
          expect_cyc("col_hit", 1, w ? 3'd3 : 3'd2, bg, bk, 16'd0, col, 0, 0, 0, 0, 0);
          done = 1;
        end
        2'b10: begin
          step(2'b00); rand_inputs();
          expect_cyc("act", 1, 3'd1, bg, bk, row, 10'd0, 0, 0, 0, 0, 0);
          if (abort) begin
            step(2'b00); rand_inputs();
            expect_nop("rcd_before_rst");
            #2;
            req_valid_i = 1'b0; ref_req_i = 1'b0;
            rst_ni = 1'b0;
            #1;
            lat_bg = 0; lat_bank = 0; lat_row = 0;
            compare_outputs("async_rst", 0, 3'd0, 2'd0, 2'd0, 16'd0, 10'd0, 0, 0, 0, 0, 1);
            @(negedge clk_i);
            rst_ni = 1'b1;
            clear_table();
            m_hit = 0; m_miss = 0; m_conf = 0;
            return;
          end
          for (int i = 0; i < T_RCD - 1; i++) begin
            step(2'b00); rand_inputs(); expect_nop("wait_rcd");
          end
          step(2'b00); rand_inputs();
          expect_cyc("col_miss", 1, w ? 3'd3 : 3'd2, bg, bk, 16'd0, col, 0, 0, 0, 0, 0);
          done = 1;
        end
        default: begin
          step(2'b00); rand_inputs();
          expect_cyc("pre", 1, 3'd4, bg, bk, 16'd0, 10'd0, 1, 1, 0, 0, 0);
          tv[{bg, bk}] = 1'b0;
          for (int i = 0; i < T_RP - 1; i++) begin
            step(2'b00); rand_inputs(); expect_nop("wait_rp");
          end
          step(2'b00); rand_inputs();
          expect_cyc("lookup2", 0, 3'd0, 2'd0, 2'd0, 16'd0, 10'd0, 1, 0, 0, 0, 0);
        end
      endcase
    end
    check("seq_complete", {63'd0, done}, 64'd1);
    for (int i = 0; i < T_BURST - 1; i++) begin
      step(2'b00); rand_inputs(); expect_nop("wait_burst");
    end
  endtask

  task automatic do_ref(input logic rv);
    step(2'b00);
    ref_req_i = 1'b1; req_valid_i = rv;
    req_write_i = 1'($urandom); req_bg_i = 2'($urandom); req_bank_i = 2'($urandom);
    req_row_i = 16'($urandom); req_col_i = 10'($urandom);
    expect_cyc("ref_idle", 0, 3'd0, 2'd0, 2'd0, 16'd0, 10'd0, 0, 0, 0, 0, 0);
    step(2'b00); rand_inputs();
    expect_cyc("prea", 1, 3'd5, 2'd0, 2'd0, 16'd0, 10'd0, 0, 0, 1, 0, 0);
    clear_table();
    for (int i = 0; i < T_RP - 1; i++) begin
      step(2'b00); rand_inputs(); expect_nop("wait_rp_ref");
    end
    step(2'b00); rand_inputs();
    expect_cyc("ref", 1, 3'd6, 2'd0, 2'd0, 16'd0, 10'd0, 0, 0, 0, 1, 0);
    for (int i = 0; i < T_RFC - 1; i++) begin
      step(2'b00); rand_inputs(); expect_nop("wait_rfc");
    end
  endtask

  initial begin
    rst_ni = 1'b0;
    req_valid_i = 0; req_write_i = 0; req_bg_i = 0; req_bank_i = 0;
    req_row_i = 0; req_col_i = 0; ref_req_i = 0; pol_row_stat_i = 0;
    lat_bg = 0; lat_bank = 0; lat_row = 0;
    m_hit = 0; m_miss = 0; m_conf = 0;
    clear_table();
    #1;
    compare_outputs("reset", 0, 3'd0, 2'd0, 2'd0, 16'd0, 10'd0, 0, 0, 0, 0, 1);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Reset in the middle of WAIT_RCD.
    do_req(0, 2'd1, 2'd2, 16'h0777, 10'h003, 0, 1);

    // Directed sequence: MISS, HIT, CONFLICT, refresh, MISS after refresh.
    do_req(0, 2'd1, 2'd2, 16'h0123, 10'h010, 0, 0);
    do_req(1, 2'd1, 2'd2, 16'h0123, 10'h011, 0, 0);
    do_req(1, 2'd1, 2'd2, 16'h0456, 10'h020, 0, 0);
    do_ref(1'b1);
    do_req(0, 2'd1, 2'd2, 16'h0456, 10'h030, 0, 0);
`ifdef DRAM_CMD_SEQ_STATS_EN
    check("stat_hit_dir", 64'(stat_hit_o), 64'(m_hit));
    check("stat_miss_dir", 64'(stat_miss_o), 64'(m_miss));
    check("stat_conflict_dir", 64'(stat_conflict_o), 64'(m_conf));
`endif

    // Random traffic over a few banks and rows, with policy retries.
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        do_ref(1'($urandom));
      end else begin
        logic [15:0] rows [3];
        rows[0] = 16'h0010; rows[1] = 16'hBEEF; rows[2] = 16'h7001;
        do_req(1'($urandom), 2'($urandom_range(0, 1)), 2'($urandom_range(0, 1)),
               rows[$urandom_range(0, 2)], 10'($urandom), 25, 0);
      end
    end
`ifdef DRAM_CMD_SEQ_STATS_EN
    check("stat_hit", 64'(stat_hit_o), 64'(m_hit));
    check("stat_miss", 64'(stat_miss_o), 64'(m_miss));
    check("stat_conflict", 64'(stat_conflict_o), 64'(m_conf));
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dram_cmd_seq.md
Name: dram_cmd_seq

Overview:
- Per-request DRAM command sequencer that sits directly downstream of the open-row policy block.
- Accepts one memory request at a time and looks the request up in the policy block.
- Based on the returned row status (HIT/MISS/CONFLICT), issues the PRE/ACT/RD/WR command sequence with tRP/tRCD/burst spacing.
- Also serialises refresh as PREA -> REF and clears the policy table when it does so.

Parameters:
- T_RCD, 4, cycles from ACT to RD/WR (min 2)
- T_RP, 4, cycles from PRE/PREA to next lookup or REF (min 2)
- T_BURST, 4, cycles from RD/WR until the next request is accepted (min 2)
- T_RFC, 8, cycles from REF until return to IDLE (min 2)
- CNT_W, 8, wait-counter width

Ports:
- CLK  in  1  clock
- nRST  in  1  async active-low reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept a request
- req_write  in  1  1=WR, 0=RD
- req_bg  in  2  bank group
- req_bank  in  2  bank
- req_row  in  16  row
- req_col  in  10  column
- ref_req  in  1  refresh request (level)
- ref_ack  out  1  one-cycle pulse when REF is issued
- pol_req_en  out  1  policy lookup strobe
- pol_row_resolve  out  1  policy invalidate of the current bank's open row
- pol_refresh  out  1  policy table clear
- pol_bank_group  out  2  lookup bank group (latched request)
- pol_bank  out  2  lookup bank (latched request)
- pol_row  out  16  lookup row (latched request)
- pol_row_stat  in  2  registered policy status: 00 IDLE, 01 HIT, 10 MISS, 11 CONFLICT
- cmd_valid  out  1  command strobe
- cmd  out  3  0 NOP, 1 ACT, 2 RD, 3 WR, 4 PRE, 5 PREA, 6 REF
- cmd_bg  out  2  command bank group
- cmd_bank  out  2  command bank
- cmd_row  out  16  row (valid for ACT, else 0)
- cmd_col  out  10  column (valid for RD/WR, else 0)

Behaviour:
- Clock and reset: one clock CLK; reset nRST is asynchronous, active-low.
- Reset state:
  - FSM = IDLE; wait counter = 0; latched request = 0.
  - All outputs 0, except req_ready, which follows the IDLE rule below.
  - Reset mid-sequence abandons the sequence; no command is completed.
- States: IDLE, LOOKUP, WAIT_STAT, ACT, WAIT_RCD, COL, WAIT_BURST, PRE, WAIT_RP, PREA, REF, WAIT_RFC.
- IDLE:
  - req_ready = !ref_req.
  - ref_req has priority over a request: ref_req -> PREA.
  - Otherwise, req_valid && req_ready latches write/bg/bank/row/col -> LOOKUP.
- LOOKUP: pol_req_en=1 for one cycle -> WAIT_STAT.
- WAIT_STAT: decode pol_row_stat (the policy output registered one cycle after req_en):
  - 01 -> COL
  - 10 -> ACT (policy has already marked the row open)
  - 11 -> PRE
  - 00 -> LOOKUP (retry)
- ACT: cmd_valid=1, cmd=ACT, cmd_row=latched row -> WAIT_RCD.
- COL: cmd_valid=1, cmd=RD or WR, cmd_col=latched col -> WAIT_BURST.
- PRE:
  - cmd=PRE.
  - Simultaneously pol_req_en=1 and pol_row_resolve=1 to invalidate the bank entry.
  - The policy's resulting status 00 is ignored.
  - -> WAIT_RP, return target LOOKUP.
- PREA: cmd=PREA, pol_refresh=1 -> WAIT_RP, return target REF.
- REF: cmd=REF, ref_ack=1 -> WAIT_RFC.
- Wait states (WAIT_x):
  - Counter loads T_x-2 on entry and decrements each cycle.
  - Exit when the counter is 0, so each wait state lasts T_x-1 cycles.
  - The next command-state is therefore exactly T_x cycles after the preceding command.
- Exits: WAIT_RCD -> COL; WAIT_BURST -> IDLE; WAIT_RFC -> IDLE.
- Timing (cycle 0 = accept cycle): HIT RD at cycle 3; MISS ACT at cycle 3, RD at 3+T_RCD; CONFLICT PRE at cycle 3, second LOOKUP at 3+T_RP, ACT at 5+T_RP, RD at 5+T_RP+T_RCD.
- Output rules:
  - cmd_bg/cmd_bank = latched request for ACT/PRE/RD/WR, 0 for PREA/REF/NOP.
  - pol_bank_group/pol_bank/pol_row always drive the latched request.
  - All command/pol outputs are decoded from registered state only (no input->output combinational path).
  - cmd_valid=0 implies cmd=NOP.
- Mid-sequence inputs: ref_req asserted mid-sequence is ignored until IDLE. req_valid is ignored when req_ready=0.
- Overflow rule: CNT_W must hold max(T_*)-2; no wrap is permitted.

Optional Feature:
- Macro DRAM_CMD_SEQ_STATS_EN.
- When defined, adds outputs stat_hit, stat_miss, stat_conflict (16 bits each).
  - Each increments in WAIT_STAT on 01/10/11 respectively.
  - Counters saturate at 16'hFFFF and reset to 0.
  - The retry path (00) counts nothing.
- When undefined, these ports and their logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset with defaults -> req_ready=1, cmd_valid=0, all pol_* outputs 0; assert nRST low mid-WAIT_RCD -> outputs 0 immediately (async), FSM IDLE.
- RD bg=1 bank=2 row=0x0123 col=0x010, empty table -> ACT row 0x0123 at cycle 3, RD col 0x010 at cycle 7, req_ready high again at cycle 11.
- Repeat same row as WR -> HIT; WR at cycle 3 with no ACT.
- Same bank, row 0x0456 -> CONFLICT; PRE with pol_req_en=pol_row_resolve=1 at cycle 3, LOOKUP at 7, ACT row 0x0456 at 9, WR/RD at 13.
- ref_req and req_valid both high in IDLE -> PREA and pol_refresh at cycle 1, REF and ref_ack at cycle 5, IDLE at 13; the next request to row 0x0456 sees MISS.
- With DRAM_CMD_SEQ_STATS_EN defined, after the sequence above -> stat_hit=1, stat_miss=3, stat_conflict=1.
